arp_resolver: RTL and testbench
===============================

// Module: arp_resolver
// PURPOSE
//  ARP initiator, the counterpart of the stack's ARP responder: resolves a destination IPv4 address to a MAC.
//  On request it broadcasts an ARP request, parses incoming ARP replies and holds the result in a 1-entry cache.
//  Sits beside the ip/udp block on the same Ethernet MAC byte interface and supplies the UDP tx dest MAC.
// PARAMETERS
//  MY_MAC          48'h00_AA_BB_CC_DD_EE   local MAC (sender hw addr, rx dst filter)
//  MY_IP           32'h0A_05_05_05         local IPv4 (sender proto addr, reply target check)
//  RETRY_TIMEOUT   12_500_000              cycles to wait for a reply after each request (100 ms @125 MHz)
//  MAX_RETRIES     3                       requests sent before declaring failure (>=1)
// PORTS
//  eth_clk            in   1   single clock; tx and rx byte streams are both synchronous to it
//  eth_rst            in   1   synchronous, active-high reset
//  resolve_req        in   1   1-cycle pulse: resolve resolve_ip
//  resolve_ip         in   32  IPv4 to resolve; sampled only when resolve_req=1
//  resolve_busy       out  1   request in progress; resolve_req ignored while high
//  resolve_done       out  1   1-cycle pulse: resolved_mac valid for resolve_ip
//  resolve_fail       out  1   1-cycle pulse: MAX_RETRIES exhausted, no reply
//  resolved_mac       out  48  cached MAC, stable until next done/fail
//  cache_valid        out  1   cache holds a valid IP->MAC entry
//  eth_tx_data        out  8   tx byte to MAC
//  eth_tx_data_en     out  1   frame in progress
//  eth_tx_ack         in   1   MAC accepted first byte; one byte per cycle thereafter
//  eth_rx_data        in   8   rx byte
//  eth_rx_data_valid  in   1   high for each frame byte, low between frames
//  eth_rx_frame_good  in   1   end-of-frame pulse, FCS ok
//  eth_rx_frame_bad   in   1   end-of-frame pulse, FCS error
// BEHAVIOUR
//  Reset: all outputs 0 (data 8'h00), state IDLE, cache invalid, retry/timeout counters 0, rx parser idle.
//  FSM IDLE -> TX_REQ -> TX_GAP -> WAIT_REPLY -> {IDLE (done) | TX_REQ (retry) | IDLE (fail)}.
//  IDLE, resolve_req: cache hit (cache_valid && ip==cached ip) -> resolve_done next cycle, no tx.
//    Miss -> latch target ip, invalidate cache, busy=1, retry_cnt=0, enter TX_REQ.
//  TX_REQ: en=1, data=byte0 held until eth_tx_ack sampled 1; byte k+1 on the cycle after byte k is accepted.
//    42-byte frame: FF x6 | MY_MAC | 08 06 | 00 01 | 08 00 | 06 04 | 00 01 | MY_MAC | MY_IP | 00 x6 | target ip.
//    en drops the cycle after byte 41; TX_GAP holds en=0 for 2 cycles; timeout counter cleared; retry_cnt+1.
//  WAIT_REPLY: timeout counter +1/cycle; at RETRY_TIMEOUT-1: retry_cnt<MAX_RETRIES -> TX_REQ,
//    else resolve_fail pulse, busy=0, IDLE.
//  Rx parser (all states): byte index rx_pos from 0 per frame, reset when data_valid=0, saturates at 2047.
//    Match requires: dst(0-5)=MY_MAC or FF*6; 12-13=0806; 14-15=0001; 16-17=0800; 18-19=0604;
//    20-21=0002 (reply); sender IP (28-31) = latched target ip; target IP (38-41) = MY_IP.
//    Sender MAC (22-27) captured to a shadow reg; any mismatch drops the frame until data_valid falls.
//  Commit only on eth_rx_frame_good after a full match while in WAIT_REPLY: resolved_mac<=shadow,
//    cache_valid=1, resolve_done pulse, busy=0, IDLE. frame_bad or frame ending <42 bytes: discarded.
//  Match outside WAIT_REPLY (TX_REQ/TX_GAP/IDLE) ignored; no cache update from unsolicited replies.
//  Simultaneous commit and timeout expiry in the same cycle: commit wins, no retry/fail.
//  resolve_req while busy: ignored, no pulse. done and fail never both high.
//  Reset mid-frame: eth_tx_data_en=0 from the next edge, frame truncated; rx parse discarded.
//  Timeout counter width $clog2(RETRY_TIMEOUT+1); retry_cnt width $clog2(MAX_RETRIES+1).
// STRUCTURE
//  Package ip_stack_pkg: ETHERTYPE_ARP/IP, ARP_HTYPE_ETH, ARP_OP_REQ/REPLY, HLEN/PLEN, BCAST_MAC,
//    ARP_FRAME_LEN=42, header length constants; shared with the responder and the ip/udp block.
//  Sub-module arp_rx_parser: rx_pos counter, field checks, sender MAC shadow, 1-cycle 'reply_ok' pulse on frame_good.
//  Top: request FSM, tx byte mux, timeout/retry counters, cache regs.
// TESTING
//  1 Miss: resolve_ip=0A050501, ack 3 cycles after en -> exact 42-byte request, en low after byte 41.
//  2 Reply from 0A050501 with MAC 308 5A9 130532 (30:85:A9:13:05:32), frame_good -> done pulse,
//    resolved_mac=48'h3085A9130532, cache_valid=1; second req same ip -> done 1 cycle later, no tx.
//  3 No reply, RETRY_TIMEOUT=100, MAX_RETRIES=3 -> exactly 3 requests ~100 cycles apart, then fail pulse.
//  4 Reply with bad FCS, wrong opcode 0001, wrong sender IP 0A050502, or target IP != MY_IP -> ignored,
//    retry continues; subsequent good reply -> done.
//  5 Good reply frame_good on the same cycle as timeout expiry -> done, no 4th request, no fail.
//  6 eth_rst at byte 20 of tx -> en=0 next cycle, all outputs 0, cache invalid; new req restarts cleanly.

Source files
------------

// File: rtl/ip_stack_pkg.sv
// Shared Ethernet/ARP constants and byte helpers for the ARP responder, ARP resolver and ip/udp block.
package ip_stack_pkg;

    localparam logic [15:0] ETHERTYPE_ARP = 16'h0806;
    localparam logic [15:0] ETHERTYPE_IP  = 16'h0800;
    localparam logic [15:0] ARP_HTYPE_ETH = 16'h0001;
    localparam logic [15:0] ARP_OP_REQ    = 16'h0001;
    localparam logic [15:0] ARP_OP_REPLY  = 16'h0002;
    localparam logic [7:0]  ARP_HLEN      = 8'h06;
    localparam logic [7:0]  ARP_PLEN      = 8'h04;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    localparam int unsigned MAC_ADDR_LEN    = 6;
    localparam int unsigned IP_ADDR_LEN     = 4;
    localparam int unsigned ETH_HDR_LEN     = 14;
    localparam int unsigned ARP_PAYLOAD_LEN = 28;
    localparam int unsigned ARP_FRAME_LEN   = ETH_HDR_LEN + ARP_PAYLOAD_LEN;

    typedef enum logic [1:0] {
        ARP_IDLE,
        ARP_TX_REQ,
        ARP_TX_GAP,
        ARP_WAIT_REPLY
    } arp_state_t;

    // Byte idx of a MAC in wire order (idx 0 = most significant octet).
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input int unsigned idx);
        return 8'(mac >> (8 * (MAC_ADDR_LEN - 1 - idx)));
    endfunction

    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input int unsigned idx);
        return 8'(ip >> (8 * (IP_ADDR_LEN - 1 - idx)));
    endfunction

    // Fixed ARP header bytes 12..21 of the frame (ethertype .. opcode), off = 0..9.
    function automatic logic [7:0] arp_hdr_byte(input int unsigned off, input logic [15:0] op);
        logic [79:0] hdr;
        hdr = {ETHERTYPE_ARP, ARP_HTYPE_ETH, ETHERTYPE_IP, ARP_HLEN, ARP_PLEN, op};
        return 8'(hdr >> (8 * (9 - off)));
    endfunction

endpackage

// File: rtl/arp_rx_parser.sv
// Streams received frames through ARP reply field checks; pulses reply_ok on frame_good after a full match.
module arp_rx_parser
    import ip_stack_pkg::*;
#(
    parameter logic [47:0] MY_MAC = 48'h00AA_BBCC_DDEE,
    parameter logic [31:0] MY_IP  = 32'h0A05_0505
) (
    input  logic        eth_clk,
    input  logic        eth_rst,
    input  logic [7:0]  eth_rx_data,
    input  logic        eth_rx_data_valid,
    input  logic        eth_rx_frame_good,
    input  logic        eth_rx_frame_bad,
    input  logic [31:0] target_ip,
    output logic        reply_ok,
    output logic [47:0] sender_mac
);

    localparam int unsigned     POS_W    = 11;
    localparam logic [POS_W-1:0] POS_MAX = '1;
    localparam logic [POS_W-1:0] POS_END = POS_W'(ARP_FRAME_LEN - 1);

    logic [POS_W-1:0] rx_pos;
    logic             match_q;
    logic             full_q;
    logic             dst_my_q;
    logic             dst_bc_q;
    logic [47:0]      shadow_q;

    logic first_c;
    logic dst_my_n;
    logic dst_bc_n;
    logic byte_ok_c;
    logic match_n;
    logic full_n;
    logic commit_c;

    function automatic logic field_ok(input logic [POS_W-1:0] p, input logic [7:0] d,
                                      input logic [31:0] tip);
        int unsigned i;
        logic        ok;
        i  = 32'(p);
        ok = 1'b1;
        if (i >= 12 && i <= 21)
            ok = (d == arp_hdr_byte(i - 12, ARP_OP_REPLY));
        else if (i >= 28 && i <= 31)
            ok = (d == ip_byte(tip, i - 28));
        else if (i >= 38 && i <= 41)
            ok = (d == ip_byte(MY_IP, i - 38));
        return ok;
    endfunction

    // Per-byte match evaluation; destination may be our MAC or broadcast.
    always_comb begin
        first_c   = (rx_pos == '0);
        dst_my_n  = (first_c | dst_my_q) & (eth_rx_data == mac_byte(MY_MAC, 32'(rx_pos)));
        dst_bc_n  = (first_c | dst_bc_q) & (eth_rx_data == mac_byte(BCAST_MAC, 32'(rx_pos)));
        byte_ok_c = (rx_pos < POS_W'(MAC_ADDR_LEN)) ? (dst_my_n | dst_bc_n)
                                                    : field_ok(rx_pos, eth_rx_data, target_ip);
        match_n   = (first_c | match_q) & byte_ok_c;
        full_n    = match_n & (rx_pos >= POS_END);
        commit_c  = eth_rx_frame_good & (eth_rx_data_valid ? full_n : full_q);
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            rx_pos     <= '0;
            match_q    <= 1'b0;
            full_q     <= 1'b0;
            dst_my_q   <= 1'b0;
            dst_bc_q   <= 1'b0;
            shadow_q   <= '0;
            reply_ok   <= 1'b0;
            sender_mac <= '0;
        end else begin
            if (eth_rx_data_valid) begin
                rx_pos   <= (rx_pos == POS_MAX) ? rx_pos : rx_pos + POS_W'(1);
                match_q  <= match_n;
                full_q   <= full_n;
                dst_my_q <= dst_my_n;
                dst_bc_q <= dst_bc_n;
                if (rx_pos >= POS_W'(22) && rx_pos <= POS_W'(27))
                    shadow_q <= {shadow_q[39:0], eth_rx_data};
            end else begin
                rx_pos <= '0;
            end
            // Any end-of-frame marker closes the frame; only a good one may commit.
            if (eth_rx_frame_good || eth_rx_frame_bad) begin
                match_q <= 1'b0;
                full_q  <= 1'b0;
            end
            reply_ok <= commit_c;
            if (commit_c)
                sender_mac <= shadow_q;
        end
    end

endmodule

// File: rtl/arp_resolver.sv
// ARP initiator: broadcasts a request for resolve_ip, retries on timeout and caches the replying MAC.
module arp_resolver
    import ip_stack_pkg::*;
#(
    parameter logic [47:0] MY_MAC        = 48'h00AA_BBCC_DDEE,
    parameter logic [31:0] MY_IP         = 32'h0A05_0505,
    parameter int unsigned RETRY_TIMEOUT = 12_500_000,
    parameter int unsigned MAX_RETRIES   = 3
) (
    input  logic        eth_clk,
    input  logic        eth_rst,
    input  logic        resolve_req,
    input  logic [31:0] resolve_ip,
    output logic        resolve_busy,
    output logic        resolve_done,
    output logic        resolve_fail,
    output logic [47:0] resolved_mac,
    output logic        cache_valid,
    output logic [7:0]  eth_tx_data,
    output logic        eth_tx_data_en,
    input  logic        eth_tx_ack,
    input  logic [7:0]  eth_rx_data,
    input  logic        eth_rx_data_valid,
    input  logic        eth_rx_frame_good,
    input  logic        eth_rx_frame_bad
);

    localparam int unsigned     TMO_W    = $clog2(RETRY_TIMEOUT + 1);
    localparam int unsigned     RET_W    = $clog2(MAX_RETRIES + 1);
    localparam int unsigned     IDX_W    = 6;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RETRY_TIMEOUT - 1);
    localparam logic [RET_W-1:0] RET_MAX  = RET_W'(MAX_RETRIES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(ARP_FRAME_LEN - 1);

    arp_state_t       state, state_n;
    logic [IDX_W-1:0] tx_idx, tx_idx_n;
    logic             tx_acked, tx_acked_n;
    logic             gap_cnt, gap_cnt_n;
    logic [TMO_W-1:0] tmo_cnt, tmo_cnt_n;
    logic [RET_W-1:0] retry_cnt, retry_cnt_n;
    logic [31:0]      target_ip, target_ip_n;
    logic             cache_valid_n;
    logic [47:0]      resolved_mac_n;
    logic             resolve_busy_n;
    logic             resolve_done_n;
    logic             resolve_fail_n;
    logic [7:0]       tx_data_n;
    logic             tx_en_n;

    logic             reply_ok;
    logic [47:0]      sender_mac;

    arp_rx_parser #(
        .MY_MAC (MY_MAC),
        .MY_IP  (MY_IP)
    ) u_rx_parser (
        .eth_clk           (eth_clk),
        .eth_rst           (eth_rst),
        .eth_rx_data       (eth_rx_data),
        .eth_rx_data_valid (eth_rx_data_valid),
        .eth_rx_frame_good (eth_rx_frame_good),
        .eth_rx_frame_bad  (eth_rx_frame_bad),
        .target_ip         (target_ip),
        .reply_ok          (reply_ok),
        .sender_mac        (sender_mac)
    );

    // Request frame byte at position idx.
    function automatic logic [7:0] tx_byte(input logic [IDX_W-1:0] idx, input logic [31:0] tip);
        int unsigned i;
        logic [7:0]  b;
        i = 32'(idx);
        b = 8'h00;
        if (i < 6)       b = mac_byte(BCAST_MAC, i);
        else if (i < 12) b = mac_byte(MY_MAC, i - 6);
        else if (i < 22) b = arp_hdr_byte(i - 12, ARP_OP_REQ);
        else if (i < 28) b = mac_byte(MY_MAC, i - 22);
        else if (i < 32) b = ip_byte(MY_IP, i - 28);
        else if (i < 38) b = 8'h00;
        else if (i < 42) b = ip_byte(tip, i - 38);
        return b;
    endfunction

    always_comb begin
        state_n        = state;
        tx_idx_n       = tx_idx;
        tx_acked_n     = tx_acked;
        gap_cnt_n      = gap_cnt;
        tmo_cnt_n      = tmo_cnt;
        retry_cnt_n    = retry_cnt;
        target_ip_n    = target_ip;
        cache_valid_n  = cache_valid;
        resolved_mac_n = resolved_mac;
        resolve_busy_n = resolve_busy;
        resolve_done_n = 1'b0;
        resolve_fail_n = 1'b0;
        tx_data_n      = eth_tx_data;
        tx_en_n        = eth_tx_data_en;

        case (state)
            ARP_IDLE: begin
                if (resolve_req) begin
                    if (cache_valid && (resolve_ip == target_ip)) begin
                        resolve_done_n = 1'b1;
                    end else begin
                        target_ip_n    = resolve_ip;
                        cache_valid_n  = 1'b0;
                        resolve_busy_n = 1'b1;
                        retry_cnt_n    = '0;
                        state_n        = ARP_TX_REQ;
                        tx_idx_n       = '0;
                        tx_acked_n     = 1'b0;
                        tx_en_n        = 1'b1;
                        tx_data_n      = tx_byte('0, resolve_ip);
                    end
                end
            end
            ARP_TX_REQ: begin
                // Byte 0 waits for ack; afterwards the MAC takes one byte per cycle.
                if (tx_acked || eth_tx_ack) begin
                    if (tx_idx == IDX_LAST) begin
                        tx_en_n     = 1'b0;
                        tx_data_n   = 8'h00;
                        state_n     = ARP_TX_GAP;
                        gap_cnt_n   = 1'b0;
                        tmo_cnt_n   = '0;
                        retry_cnt_n = retry_cnt + RET_W'(1);
                    end else begin
                        tx_idx_n   = tx_idx + IDX_W'(1);
                        tx_data_n  = tx_byte(tx_idx + IDX_W'(1), target_ip);
                        tx_acked_n = 1'b1;
                    end
                end
            end
            ARP_TX_GAP: begin
                if (gap_cnt) state_n = ARP_WAIT_REPLY;
                else         gap_cnt_n = 1'b1;
            end
            ARP_WAIT_REPLY: begin
                // A commit takes priority over a coincident timeout.
                if (reply_ok) begin
                    resolved_mac_n = sender_mac;
                    cache_valid_n  = 1'b1;
                    resolve_done_n = 1'b1;
                    resolve_busy_n = 1'b0;
                    state_n        = ARP_IDLE;
                end else if (tmo_cnt == TMO_LAST) begin
                    if (retry_cnt < RET_MAX) begin
                        state_n    = ARP_TX_REQ;
                        tx_idx_n   = '0;
                        tx_acked_n = 1'b0;
                        tx_en_n    = 1'b1;
                        tx_data_n  = tx_byte('0, target_ip);
                    end else begin
                        resolve_fail_n = 1'b1;
                        resolve_busy_n = 1'b0;
                        state_n        = ARP_IDLE;
                    end
                end else begin
                    tmo_cnt_n = tmo_cnt + TMO_W'(1);
                end
            end
            default: state_n = ARP_IDLE;
        endcase
    end

    always_ff @(posedge eth_clk) begin
        if (eth_rst) begin
            state          <= ARP_IDLE;
            tx_idx         <= '0;
            tx_acked       <= 1'b0;
            gap_cnt        <= 1'b0;
            tmo_cnt        <= '0;
            retry_cnt      <= '0;
            target_ip      <= '0;
            cache_valid    <= 1'b0;
            resolved_mac   <= '0;
            resolve_busy   <= 1'b0;
            resolve_done   <= 1'b0;
            resolve_fail   <= 1'b0;
            eth_tx_data    <= 8'h00;
            eth_tx_data_en <= 1'b0;
        end else begin
            state          <= state_n;
            tx_idx         <= tx_idx_n;
            tx_acked       <= tx_acked_n;
            gap_cnt        <= gap_cnt_n;
            tmo_cnt        <= tmo_cnt_n;
            retry_cnt      <= retry_cnt_n;
            target_ip      <= target_ip_n;
            cache_valid    <= cache_valid_n;
            resolved_mac   <= resolved_mac_n;
            resolve_busy   <= resolve_busy_n;
            resolve_done   <= resolve_done_n;
            resolve_fail   <= resolve_fail_n;
            eth_tx_data    <= tx_data_n;
            eth_tx_data_en <= tx_en_n;
        end
    end

endmodule

// File: tb/tb_arp_resolver.sv
// Scoreboard bench for arp_resolver: expected tx frames and done/fail events are queued by the stimulus.
module tb_arp_resolver;

    localparam int T_OUT = 100;
    localparam int PERIOD_REQ = 147;  // 45 tx cycles (ack after 3) + 2 gap + 100 wait
    localparam logic [47:0] MAC_A = 48'h3085_A913_0532;
    localparam logic [47:0] MAC_B = 48'h0212_3456_789A;
    localparam logic [47:0] MAC_C = 48'hA45E_6011_2233;
    localparam logic [47:0] LOCAL_MAC = 48'h00AA_BBCC_DDEE;
    localparam logic [31:0] LOCAL_IP  = 32'h0A05_0505;

    typedef struct { logic [31:0] tip; int len; } txe_t;
    typedef struct { bit is_fail; logic [47:0] mac; } ev_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        resolve_req;
    logic [31:0] resolve_ip;
    logic        resolve_busy, resolve_done, resolve_fail, cache_valid;
    logic [47:0] resolved_mac;
    logic [7:0]  eth_tx_data;
    logic        eth_tx_data_en;
    logic        eth_tx_ack;
    logic [7:0]  eth_rx_data;
    logic        eth_rx_data_valid, eth_rx_frame_good, eth_rx_frame_bad;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    txe_t exp_tx[$];
    ev_t  exp_ev[$];
    int   tx_start[$];
    int   tx_end[$];

    arp_resolver #(
        .MY_MAC        (LOCAL_MAC),
        .MY_IP         (LOCAL_IP),
        .RETRY_TIMEOUT (T_OUT),
        .MAX_RETRIES   (3)
    ) dut (
        .eth_clk           (clk),
        .eth_rst           (rst),
        .resolve_req       (resolve_req),
        .resolve_ip        (resolve_ip),
        .resolve_busy      (resolve_busy),
        .resolve_done      (resolve_done),
        .resolve_fail      (resolve_fail),
        .resolved_mac      (resolved_mac),
        .cache_valid       (cache_valid),
        .eth_tx_data       (eth_tx_data),
        .eth_tx_data_en    (eth_tx_data_en),
        .eth_tx_ack        (eth_tx_ack),
        .eth_rx_data       (eth_rx_data),
        .eth_rx_data_valid (eth_rx_data_valid),
        .eth_rx_frame_good (eth_rx_frame_good),
        .eth_rx_frame_bad  (eth_rx_frame_bad)
    );

    always #4 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s wait expired at cycle %0d", name, cyc);
    endtask

    function automatic logic [7:0] exp_tx_byte(input int i, input logic [31:0] tip);
        logic [335:0] f;
        f = {48'hFFFF_FFFF_FFFF, 48'h00AA_BBCC_DDEE, 16'h0806, 16'h0001, 16'h0800, 16'h0604,
             16'h0001, 48'h00AA_BBCC_DDEE, 32'h0A05_0505, 48'h0, tip};
        return f[335 - 8*i -: 8];
    endfunction

    // tx side: emulate the MAC (ack 3 cycles after en) and score each frame.
    initial begin : tx_mon
        logic [7:0] got [0:63];
        int   n;
        int   nbad;
        bit   fin;
        txe_t e;
        eth_tx_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (eth_tx_data_en) begin
                tx_start.push_back(cyc);
                n = 0;
                for (int k = 0; k < 3 && eth_tx_data_en; k++) @(negedge clk);
                if (eth_tx_data_en) begin
                    eth_tx_ack = 1'b1;
                    got[0] = eth_tx_data;
                    n = 1;
                    fin = 1'b0;
                    while (!fin) begin
                        @(negedge clk);
                        eth_tx_ack = 1'b0;
                        if (!eth_tx_data_en || n == 64) fin = 1'b1;
                        else begin got[n] = eth_tx_data; n++; end
                    end
                end
                tx_end.push_back(cyc);
                if (exp_tx.size() == 0) begin
                    timeout_fail("tx_unexpected_frame");
                end else begin
                    e = exp_tx.pop_front();
                    check("tx_len", 64'(n), 64'(e.len));
                    nbad = 0;
                    for (int i = 0; i < n && i < 42; i++)
                        if (got[i] !== exp_tx_byte(i, e.tip)) nbad++;
                    check("tx_bytes_wrong", 64'(nbad), 64'd0);
                end
            end
        end
    end

    // Result side: every done/fail pulse must match the next queued expectation.
    initial begin : ev_mon
        ev_t e;
        forever begin
            @(negedge clk);
            if (resolve_done || resolve_fail) begin
                check("done_fail_exclusive", 64'(resolve_done & resolve_fail), 64'd0);
                if (exp_ev.size() == 0) begin
                    timeout_fail("ev_unexpected_pulse");
                end else begin
                    e = exp_ev.pop_front();
                    check("ev_is_fail", 64'(resolve_fail), 64'(e.is_fail));
                    check("ev_busy_low", 64'(resolve_busy), 64'd0);
                    if (!e.is_fail) begin
                        check("ev_mac", 64'(resolved_mac), 64'(e.mac));
                        check("ev_cache_valid", 64'(cache_valid), 64'd1);
                    end else begin
                        check("ev_cache_valid", 64'(cache_valid), 64'd0);
                    end
                end
            end
        end
    end

    task automatic issue_req(input logic [31:0] ip);
        resolve_req = 1'b1;
        resolve_ip  = ip;
        @(negedge clk);
        resolve_req = 1'b0;
        resolve_ip  = 32'h0;
    endtask

    task automatic send_frame(input logic [47:0] dst, input logic [15:0] op, input logic [47:0] smac,
                              input logic [31:0] sip, input logic [31:0] tip, input bit bad);
        logic [335:0] f;
        f = {dst, smac, 16'h0806, 16'h0001, 16'h0800, 16'h0604, op, smac, sip, LOCAL_MAC, tip};
        for (int i = 0; i < 42; i++) begin
            eth_rx_data       = f[335 - 8*i -: 8];
            eth_rx_data_valid = 1'b1;
            @(negedge clk);
        end
        eth_rx_data       = 8'h00;
        eth_rx_data_valid = 1'b0;
        eth_rx_frame_good = !bad;
        eth_rx_frame_bad  = bad;
        @(negedge clk);
        eth_rx_frame_good = 1'b0;
        eth_rx_frame_bad  = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic wait_tx_end(input int idx, output int g1);
        int budget;
        budget = 0;
        while (tx_end.size() <= idx && budget < 600) begin @(negedge clk); budget++; end
        if (tx_end.size() <= idx) begin timeout_fail("wait_tx_end"); g1 = cyc; end
        else g1 = tx_end[idx];
    endtask

    task automatic wait_idle(input string name);
        int budget;
        budget = 0;
        while (resolve_busy && budget < 1000) begin @(negedge clk); budget++; end
        if (resolve_busy) timeout_fail(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_tx_en"}, 64'(eth_tx_data_en), 64'd0);
        check({tag, "_tx_data"}, 64'(eth_tx_data), 64'd0);
        check({tag, "_busy"}, 64'(resolve_busy), 64'd0);
        check({tag, "_done"}, 64'(resolve_done), 64'd0);
        check({tag, "_fail"}, 64'(resolve_fail), 64'd0);
        check({tag, "_mac"}, 64'(resolved_mac), 64'd0);
        check({tag, "_cache_valid"}, 64'(cache_valid), 64'd0);
    endtask

    initial begin : stim
        int g1;
        int base;
        int s;
        int budget;
        rst = 1'b1;
        resolve_req = 1'b0;
        resolve_ip = 32'h0;
        eth_rx_data = 8'h00;
        eth_rx_data_valid = 1'b0;
        eth_rx_frame_good = 1'b0;
        eth_rx_frame_bad = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // 1+2: miss -> request, reply -> done; then cache hit answers next cycle with no tx.
        base = tx_end.size();
        exp_tx.push_back('{32'h0A05_0501, 42});
        exp_ev.push_back('{1'b0, MAC_A});
        issue_req(32'h0A05_0501);
        wait_tx_end(base, g1);
        wait_until(g1 + 5);
        send_frame(LOCAL_MAC, 16'h0002, MAC_A, 32'h0A05_0501, LOCAL_IP, 1'b0);
        wait_idle("wait_idle_reply");
        check("cache_valid_after_reply", 64'(cache_valid), 64'd1);
        base = tx_start.size();
        exp_ev.push_back('{1'b0, MAC_A});
        issue_req(32'h0A05_0501);
        check("hit_done_next_cycle", 64'(resolve_done), 64'd1);
        repeat (10) @(negedge clk);
        check("hit_no_tx", 64'(tx_start.size() - base), 64'd0);

        // 3: no reply -> exactly 3 requests one period apart, then fail.
        base = tx_start.size();
        for (int i = 0; i < 3; i++) exp_tx.push_back('{32'h0A05_0509, 42});
        exp_ev.push_back('{1'b1, 48'h0});
        issue_req(32'h0A05_0509);
        wait_idle("wait_idle_fail");
        check("fail_request_count", 64'(tx_start.size() - base), 64'd3);
        if (tx_start.size() - base == 3) begin
            check("retry_spacing_1", 64'(tx_start[base+1] - tx_start[base]), 64'(PERIOD_REQ));
            check("retry_spacing_2", 64'(tx_start[base+2] - tx_start[base+1]), 64'(PERIOD_REQ));
        end

        // 4: four defective replies are ignored, busy req is ignored, third request answered.
        base = tx_end.size();
        for (int i = 0; i < 3; i++) exp_tx.push_back('{32'h0A05_0501, 42});
        exp_ev.push_back('{1'b0, MAC_B});
        issue_req(32'h0A05_0501);
        wait_tx_end(base, g1);
        wait_until(g1 + 2);
        send_frame(LOCAL_MAC, 16'h0002, 48'hDEAD_BEEF_0001, 32'h0A05_0501, LOCAL_IP, 1'b1);
        send_frame(LOCAL_MAC, 16'h0001, 48'hDEAD_BEEF_0002, 32'h0A05_0501, LOCAL_IP, 1'b0);
        wait_tx_end(base + 1, g1);
        wait_until(g1 + 2);
        issue_req(32'h0A05_05FF);
        send_frame(LOCAL_MAC, 16'h0002, 48'hDEAD_BEEF_0003, 32'h0A05_0502, LOCAL_IP, 1'b0);
        send_frame(LOCAL_MAC, 16'h0002, 48'hDEAD_BEEF_0004, 32'h0A05_0501, 32'h0A05_0506, 1'b0);
        wait_tx_end(base + 2, g1);
        wait_until(g1 + 2);
        send_frame(LOCAL_MAC, 16'h0002, MAC_B, 32'h0A05_0501, LOCAL_IP, 1'b0);
        wait_idle("wait_idle_filtered");
        check("filtered_request_count", 64'(tx_end.size() - base), 64'd3);

        // 5: reply commit lands on the same cycle as timeout expiry -> done, no retry.
        base = tx_end.size();
        exp_tx.push_back('{32'h0A05_0507, 42});
        exp_ev.push_back('{1'b0, MAC_C});
        issue_req(32'h0A05_0507);
        wait_tx_end(base, g1);
        wait_until(g1 + T_OUT - 42);
        send_frame(48'hFFFF_FFFF_FFFF, 16'h0002, MAC_C, 32'h0A05_0507, LOCAL_IP, 1'b0);
        wait_idle("wait_idle_race");
        repeat (300) @(negedge clk);
        check("race_no_retry", 64'(tx_start.size() - base), 64'd1);

        // 6: reset during byte 20 of a request truncates it; next request is clean.
        exp_tx.push_back('{32'h0A05_0503, 21});
        issue_req(32'h0A05_0503);
        budget = 0;
        while (!eth_tx_data_en && budget < 20) begin @(negedge clk); budget++; end
        if (!eth_tx_data_en) timeout_fail("wait_tx_en");
        s = cyc;
        wait_until(s + 23);
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("midreset");
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        base = tx_end.size();
        exp_tx.push_back('{32'h0A05_0501, 42});
        exp_ev.push_back('{1'b0, MAC_A});
        issue_req(32'h0A05_0501);
        wait_tx_end(base, g1);
        wait_until(g1 + 3);
        send_frame(LOCAL_MAC, 16'h0002, MAC_A, 32'h0A05_0501, LOCAL_IP, 1'b0);
        wait_idle("wait_idle_after_reset");
        repeat (5) @(negedge clk);

        check("pending_tx", 64'(exp_tx.size()), 64'd0);
        check("pending_ev", 64'(exp_ev.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
